// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared states, instruction classes, opcodes and selector encodings for the multi-cycle MIPS controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        R_EXEC   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        JUMP     = 4'd12,
        JAL      = 4'd13,
        JR       = 4'd14
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_JR, C_MEM, C_BR, C_IMM, C_J, C_JAL, C_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] ASB_B    = 2'b00;
    localparam logic [1:0] ASB_4    = 2'b01;
    localparam logic [1:0] ASB_IMM  = 2'b10;
    localparam logic [1:0] ASB_IMM2 = 2'b11;

    localparam logic [1:0] PCS_ALU = 2'b00;
    localparam logic [1:0] PCS_OUT = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
    localparam logic [1:0] PCS_A   = 2'b11;

    localparam logic [1:0] AOP_ADD = 2'b00;
    localparam logic [1:0] AOP_SUB = 2'b01;
    localparam logic [1:0] AOP_FN  = 2'b10;
    localparam logic [1:0] AOP_SLT = 2'b11;

endpackage

// File: rtl/mc_controller_if.sv
// mc_controller_if: controller <-> datapath bundle
//   inputs to controller : opcode, funct (from IR), zero (ALU), mem_ready (memory handshake)
//   outputs of controller: memory/IR/PC/regfile enables, mux selectors, alu_op, instr_done, illegal_op
//   master = controller view, slave = datapath view
interface mc_controller_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_read, mem_write, iord, ir_write, pc_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op,
               instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_read, mem_write, iord, ir_write, pc_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op,
               instr_done, illegal_op
    );
endinterface

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode: combinational opcode/funct to instruction class
//   i_opcode, i_funct : IR fields
//   o_class           : instruction class driving the DECODE branch
//   o_illegal         : unsupported opcode or R-type funct
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output iclass_t    o_class,
    output logic       o_illegal
);
    logic w_r_ok;

    assign w_r_ok = (i_funct == FN_ADD) || (i_funct == FN_SUB) || (i_funct == FN_AND) ||
                    (i_funct == FN_OR)  || (i_funct == FN_SLT);

    always_comb begin
        o_class = C_ILL;
        case (i_opcode)
            OP_RTYPE:        o_class = (i_funct == FN_JR) ? C_JR : w_r_ok ? C_R : C_ILL;
            OP_LW, OP_SW:    o_class = C_MEM;
            OP_BEQ, OP_BNE:  o_class = C_BR;
            OP_ADDI, OP_SLTI: o_class = C_IMM;
            OP_J:            o_class = C_J;
            OP_JAL:          o_class = C_JAL;
            default:         o_class = C_ILL;
        endcase
    end

    assign o_illegal = (o_class == C_ILL);
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mc_controller_if.master (opcode/funct/zero/mem_ready in; enables, selectors, alu_op, pulses out)
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [1:0] RA_SEL = RD_RA
) (
    input logic             clk,
    input logic             rst_n,
    mc_controller_if.master bus
);
    state_t     r_state;
    state_t     w_next;
    iclass_t    w_class;
    logic       w_illegal;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_reg_write;
    logic [1:0] w_reg_dst;
    logic [1:0] w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_src;
    logic [1:0] w_alu_op;
    logic       w_done;
    logic       w_illegal_op;

    mc_opcode_decode u_dec (
        .i_opcode  (bus.opcode),
        .i_funct   (bus.funct),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_RESET;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_reg_dst    = RD_RT;
        w_mem_to_reg = M2R_ALU;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = ASB_B;
        w_pc_src     = PCS_ALU;
        w_alu_op     = AOP_ADD;
        w_done       = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_RESET: w_next = FETCH;
            FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = ASB_4;
                w_ir_write  = bus.mem_ready;
                w_pc_write  = bus.mem_ready;
                w_next      = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // precompute the branch target into ALUOut while the class resolves
                w_alu_src_b  = ASB_IMM2;
                w_illegal_op = w_illegal;
                w_done       = w_illegal;
                case (w_class)
                    C_R:     w_next = R_EXEC;
                    C_JR:    w_next = JR;
                    C_MEM:   w_next = MEM_ADDR;
                    C_BR:    w_next = BRANCH;
                    C_IMM:   w_next = I_EXEC;
                    C_J:     w_next = JUMP;
                    C_JAL:   w_next = JAL;
                    default: w_next = FETCH;
                endcase
            end
            R_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = AOP_FN;
                w_next      = R_WB;
            end
            R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = RD_RD;
                w_done      = 1'b1;
                w_next      = FETCH;
            end
            MEM_ADDR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ASB_IMM;
                w_next      = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                w_next     = bus.mem_ready ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = M2R_MDR;
                w_done       = 1'b1;
                w_next       = FETCH;
            end
            MEM_WR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_done      = bus.mem_ready;
                w_next      = bus.mem_ready ? FETCH : MEM_WR;
            end
            BRANCH: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = AOP_SUB;
                w_pc_src    = PCS_OUT;
                w_pc_write  = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                w_done      = 1'b1;
                w_next      = FETCH;
            end
            I_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = ASB_IMM;
                w_alu_op    = (bus.opcode == OP_SLTI) ? AOP_SLT : AOP_ADD;
                w_next      = I_WB;
            end
            I_WB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                w_next      = FETCH;
            end
            JUMP: begin
                w_pc_src   = PCS_JMP;
                w_pc_write = 1'b1;
                w_done     = 1'b1;
                w_next     = FETCH;
            end
            JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                w_reg_write  = 1'b1;
                w_reg_dst    = RA_SEL;
                w_mem_to_reg = M2R_PC;
                w_pc_src     = PCS_JMP;
                w_pc_write   = 1'b1;
                w_done       = 1'b1;
                w_next       = FETCH;
            end
            JR: begin
                w_alu_src_a = 1'b1;
                w_pc_src    = PCS_A;
                w_pc_write  = 1'b1;
                w_done      = 1'b1;
                w_next      = FETCH;
            end
            default: w_next = S_RESET;
        endcase
    end

    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_mem_write;
    assign bus.iord       = w_iord;
    assign bus.ir_write   = w_ir_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_op     = w_alu_op;
    assign bus.instr_done = w_done;
    assign bus.illegal_op = w_illegal_op;
endmodule
